// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory loader.
//   state_t  - loader FSM states
//   lane_t   - byte-lane index inside a 32-bit instruction word
//   NOP_WORD - value driven on the fetch port when no valid word is available
package imem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    typedef logic [1:0] lane_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles a little-endian byte stream into 32-bit words.
//   clk, reset  - clock and asynchronous active-high reset
//   clear       - synchronous clear of lanes and byte count (new load)
//   beat        - byte_in is consumed on this edge
//   byte_in     - incoming byte, written into lane [count]
//   count       - number of bytes currently held (lane index of next byte)
//   word_ready  - this beat completes a word (count == 3 and beat)
//   word        - completed word when word_ready, otherwise the partial word
//                 with lanes at or above count forced to zero
module byte_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        beat,
    input  logic [7:0]  byte_in,
    output lane_t       count,
    output logic        word_ready,
    output logic [31:0] word
);

    logic [3:0][7:0] lane_r;
    lane_t           cnt_r;

    // Lane storage and byte counter; the counter wraps naturally mod 4.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_r <= 32'h0000_0000;
            cnt_r  <= 2'd0;
        end else if (clear) begin
            lane_r <= 32'h0000_0000;
            cnt_r  <= 2'd0;
        end else if (beat) begin
            lane_r[cnt_r] <= byte_in;
            cnt_r         <= cnt_r + 2'd1;
        end else begin
            lane_r <= lane_r;
            cnt_r  <= cnt_r;
        end
    end

    // The word completing on this beat bypasses the lane register so the
    // caller can write it to memory on the same edge the 4th byte arrives.
    always_comb begin
        word_ready = beat & (cnt_r == 2'd3);
        word       = NOP_WORD;
        if (word_ready) begin
            word = {byte_in, lane_r[2], lane_r[1], lane_r[0]};
        end else begin
            word = {8'h00,
                    (cnt_r > 2'd2) ? lane_r[2] : 8'h00,
                    (cnt_r > 2'd1) ? lane_r[1] : 8'h00,
                    (cnt_r > 2'd0) ? lane_r[0] : 8'h00};
        end
    end

    assign count = cnt_r;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: instruction memory with a streaming byte loader.
//   clk, reset        - clock and asynchronous active-high reset
//   imem_addr_F       - fetch byte address
//   instr_F           - word at imem_addr_F (zero on fault or while stalled)
//   addr_fault_F      - address misaligned or outside DEPTH*4 bytes
//   cpu_stall         - high whenever a load sequence is active
//   load_start        - begin a new load (honoured only in IDLE)
//   load_valid/byte/last, load_ready - byte-stream handshake
//   load_done         - one-cycle pulse on clean completion
//   load_error        - sticky overflow flag, cleared by the next load_start
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 64,
    parameter int IW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] imem_addr_F,
    output logic [IW-1:0] instr_F,
    output logic          addr_fault_F,
    output logic          cpu_stall,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [7:0]    load_byte,
    input  logic          load_last,
    output logic          load_ready,
    output logic          load_done,
    output logic          load_error
);

    localparam int IDXW = $clog2(DEPTH);
    localparam int PTRW = IDXW + 1;

    logic [IW-1:0]   mem_r [DEPTH];
    state_t          state_r;
    state_t          state_nxt_s;
    logic [PTRW-1:0] ptr_r;
    logic            load_error_r;

    logic            ready_s;
    logic            beat_s;
    logic            ptr_full_s;
    logic            clear_s;
    logic            accept_s;
    logic            overflow_s;
    logic            wr_en_s;
    lane_t           pk_count_s;
    logic            pk_word_ready_s;
    logic [31:0]     pk_word_s;
    logic [IDXW-1:0] rd_idx_s;
    logic            fault_s;

    assign ready_s    = (state_r == ST_LOAD) | (state_r == ST_ERR);
    assign beat_s     = load_valid & ready_s;
    assign ptr_full_s = (ptr_r == PTRW'(DEPTH));
    assign clear_s    = (state_r == ST_IDLE) & load_start;
    // A beat in LOAD with the array already full is dropped and flags overflow.
    assign accept_s   = beat_s & (state_r == ST_LOAD) & ~ptr_full_s;
    assign overflow_s = beat_s & (state_r == ST_LOAD) & ptr_full_s;
    assign wr_en_s    = pk_word_ready_s | (state_r == ST_FLUSH);

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear_s),
        .beat       (accept_s),
        .byte_in    (load_byte),
        .count      (pk_count_s),
        .word_ready (pk_word_ready_s),
        .word       (pk_word_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_start) state_nxt_s = ST_LOAD;
                else            state_nxt_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (beat_s) begin
                    if (ptr_full_s) begin
                        // An overflowing final byte ends the stream right here.
                        if (load_last) state_nxt_s = ST_IDLE;
                        else           state_nxt_s = ST_ERR;
                    end else if (load_last) begin
                        // Count 3 before the beat means the word just closed.
                        if (pk_count_s == 2'd3) state_nxt_s = ST_DONE;
                        else                    state_nxt_s = ST_FLUSH;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_FLUSH: state_nxt_s = ST_DONE;
            ST_DONE:  state_nxt_s = ST_IDLE;
            ST_ERR: begin
                if (beat_s & load_last) state_nxt_s = ST_IDLE;
                else                    state_nxt_s = ST_ERR;
            end
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Word pointer: restarts at each load, advances on every word written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= {PTRW{1'b0}};
        end else if (clear_s) begin
            ptr_r <= {PTRW{1'b0}};
        end else if (wr_en_s) begin
            ptr_r <= ptr_r + {{(PTRW-1){1'b0}}, 1'b1};
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_error_r <= 1'b0;
        end else if (clear_s) begin
            load_error_r <= 1'b0;
        end else if (overflow_s) begin
            load_error_r <= 1'b1;
        end else begin
            load_error_r <= load_error_r;
        end
    end

    // Word array: cleared by reset, written only at the load pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= NOP_WORD;
            end
        end else if (wr_en_s) begin
            mem_r[ptr_r[IDXW-1:0]] <= pk_word_s;
        end
    end

    // Fetch port: zero-latency read, gated to zero on fault or during a load.
    assign rd_idx_s = imem_addr_F[IDXW+1:2];
    assign fault_s  = (imem_addr_F[1:0] != 2'b00) | (|imem_addr_F[AW-1:IDXW+2]);

    assign addr_fault_F = fault_s;
    assign instr_F      = (fault_s | cpu_stall) ? NOP_WORD : mem_r[rd_idx_s];
    assign cpu_stall    = (state_r != ST_IDLE);
    assign load_ready   = ready_s;
    assign load_done    = (state_r == ST_DONE);
    assign load_error   = load_error_r;

endmodule
